serial_sub8: RTL and testbench
==============================

Name: serial_sub8

Overview:
- Bit-serial two's-complement subtractor: computes d = a - b LSB-first, one bit per clock, and flags signed overflow.
- Counterpart to the team's combinational 8-bit signed adder/overflow block. Used where area matters more than latency; results feed the same downstream signed-compare logic.
- Valid/ready on both input and output sides.

Parameters:
- WIDTH, 8, operand/result width in bits (must be >= 2).

Ports:
- clk  input  1  rising-edge clock
- areset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend, two's complement
- b  input  WIDTH  subtrahend, two's complement
- out_valid  output  1  result d/overflow valid
- out_ready  input  1  consumer accepts result
- d  output  WIDTH  a - b modulo 2^WIDTH
- overflow  output  1  signed overflow of a - b

Behaviour:
- Reset:
  - areset_n low forces state IDLE, in_ready=1, out_valid=0, d=0, overflow=0, counter=0, carry=1, operand shift registers=0.
  - Reset takes effect immediately and async, including mid-RUN; the partial result is discarded.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a into A_sh and ~b into B_sh, set carry=1, cnt=0, record a_msb and b_msb; go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle:
    - sum bit = A_sh[0]^B_sh[0]^carry; carry = maj(A_sh[0],B_sh[0],carry).
    - Sum bit is shifted into the MSB of the result register (right shift); A_sh and B_sh shift right.
    - cnt increments. When cnt==WIDTH-1 (last bit), go to DONE.
  - DONE: out_valid=1, d and overflow stable. On out_ready, go to IDLE; d/overflow hold their values, out_valid drops next cycle.
- Latency:
  - Accept edge at cycle 0; out_valid first high at cycle WIDTH+1 after the accepting edge, i.e. exactly WIDTH RUN cycles.
  - Throughput is one op per WIDTH+2 cycles minimum (includes the IDLE cycle). No accept in the same cycle as the out handshake.
- Overflow rule: overflow = (a_msb != b_msb) && (d[WIDTH-1] != a_msb), evaluated on the final result and registered entering DONE. The final carry is not used.
- Ignored inputs:
  - in_valid is ignored outside IDLE; a/b changes during RUN have no effect.
  - out_ready is ignored outside DONE.
- Backpressure: out_valid stays high with d/overflow unchanged for any number of cycles until out_ready.
- Arithmetic is modulo 2^WIDTH; d is correct even when overflow=1.

Optional Feature:
- SERIAL_SUB_SAT_EN defined: on entering DONE with overflow=1, d is clamped:
  - to the max positive value (0111…1) when a_msb=0;
  - to the min negative value (1000…0) when a_msb=1.
  - overflow still reports 1.
- Undefined: d is the wrapped result. No extra logic is instantiated.

Decomposition:
- Package serial_sub_pkg: state enum (IDLE, RUN, DONE), SERIAL_SUB_DEF_WIDTH=8, function maj3.
- Sub-module fa_cell (single-bit full adder: a, b, cin -> s, cout) instantiated once as the serial datapath. Everything else stays in serial_sub8.

Test Plan:
- a=0x05, b=0x03 -> after 8 RUN cycles out_valid=1, d=0x02, overflow=0.
- a=0x80, b=0x01 -> d=0x7F, overflow=1; with SERIAL_SUB_SAT_EN -> d=0x80, overflow=1.
- a=0x7F, b=0xFF -> d=0x80, overflow=1; with SAT -> d=0x7F. Also a=0x00, b=0x80 -> d=0x80, overflow=1.
- Backpressure: a=0x10, b=0x20 with out_ready low for 3 cycles -> out_valid held, d=0xF0, overflow=0 stable; in_ready=0 throughout; one cycle after out_ready, in_ready=1.
- Reset mid-RUN:
  - areset_n low at RUN cycle 4 -> same cycle in_ready=1, out_valid=0, d=0.
  - Next op a=0x01, b=0x01 -> d=0x00, overflow=0.
- Ignore during RUN: toggle in_valid with a=0xFF, b=0x00 while RUN for a=0x40, b=0xC0 -> result d=0x80, overflow=1, no second op started.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared types, defaults and helpers for the bit-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_sub_pkg;

    localparam int SERIAL_SUB_DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fa_cell.sv
// ============================================================================
// Module      : fa_cell
// Description : Single-bit full adder used as the serial datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fa_cell
    import serial_sub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = maj3(a, b, cin);

endmodule

`default_nettype wire

// File: rtl/serial_sub8.sv
// ============================================================================
// Module      : serial_sub8
// Description : Bit-serial two's-complement subtractor d = a - b, LSB first,
//               with signed overflow flag and valid/ready on both sides.
//               Define SERIAL_SUB_SAT_EN to saturate d on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_sub8
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             overflow
);

    localparam int                c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_d;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_carry;
    logic               r_ovf;
    logic               r_a_msb;
    logic               r_b_msb;

    logic               w_sum;
    logic               w_cout;
    logic               w_last;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_d_shift;
    logic [WIDTH-1:0]   w_d_final;

    // Subtraction as a + ~b + 1: B_sh holds ~b and the carry starts at 1.
    fa_cell u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .s    (w_sum),
        .cout (w_cout)
    );

    assign w_last    = (r_cnt == c_last);
    assign w_d_shift = {w_sum, r_d[WIDTH-1:1]};
    assign w_ovf     = (r_a_msb != r_b_msb) && (w_sum != r_a_msb);

`ifdef SERIAL_SUB_SAT_EN
    localparam logic [WIDTH-1:0] c_max_pos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

    assign w_d_final = w_ovf ? (r_a_msb ? c_min_neg : c_max_pos) : w_d_shift;
`else
    assign w_d_final = w_d_shift;
`endif

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b1;
            r_ovf   <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sh  <= a;
                        r_b_sh  <= ~b;
                        r_carry <= 1'b1;
                        r_cnt   <= '0;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                    end
                end
                RUN: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + c_one;
                    // The final bit completes the result; overflow is judged on it.
                    if (w_last) begin
                        r_d   <= w_d_final;
                        r_ovf <= w_ovf;
                    end else begin
                        r_d   <= w_d_shift;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign d        = r_d;
    assign overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_sub8.sv
// ============================================================================
// Module      : tb_serial_sub8
// Description : Directed, table-driven self-checking bench for serial_sub8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_sub8;

    localparam int WIDTH = 8;

    logic             clk;
    logic             areset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             overflow;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] d_wrap;
        logic [7:0] d_sat;
        logic       ovf;
    } vec_t;

    vec_t vecs[14];

    serial_sub8 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pick_d(input vec_t v);
`ifdef SERIAL_SUB_SAT_EN
        return v.d_sat;
`else
        return v.d_wrap;
`endif
    endfunction

    // One full transaction; hold = cycles of out_ready low in DONE,
    // noise = wiggle in_valid/a/b while busy (must be ignored).
    task automatic do_op(input string nm, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic [7:0] ed, input logic eo, input int hold, input bit noise);
        int lat;
        bit busy_ok;
        @(negedge clk);
        chk({nm, " in_ready idle"}, 32'(in_ready), 32'd1);
        a = ta;
        b = tb_v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 50) begin
            if (in_ready) busy_ok = 1'b0;
            if (noise) begin
                in_valid = ~in_valid;
                a = 8'hFF;
                b = 8'h00;
            end
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(WIDTH));
        chk({nm, " in_ready low in RUN"}, 32'(busy_ok), 32'd1);
        if (noise) begin
            in_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            chk({nm, " held out_valid"}, 32'(out_valid), 32'd1);
            chk({nm, " held d"}, 32'(d), 32'(ed));
            chk({nm, " held ovf"}, 32'(overflow), 32'(eo));
            chk({nm, " held in_ready"}, 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        chk({nm, " d"}, 32'(d), 32'(ed));
        chk({nm, " overflow"}, 32'(overflow), 32'(eo));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk({nm, " out_valid drop"}, 32'(out_valid), 32'd0);
        chk({nm, " in_ready back"}, 32'(in_ready), 32'd1);
        chk({nm, " d hold after"}, 32'(d), 32'(ed));
    endtask

    initial begin
        vecs[0]  = '{8'h05, 8'h03, 8'h02, 8'h02, 1'b0};
        vecs[1]  = '{8'h80, 8'h01, 8'h7F, 8'h80, 1'b1};
        vecs[2]  = '{8'h7F, 8'hFF, 8'h80, 8'h7F, 1'b1};
        vecs[3]  = '{8'h00, 8'h80, 8'h80, 8'h7F, 1'b1};
        vecs[4]  = '{8'h10, 8'h20, 8'hF0, 8'hF0, 1'b0};
        vecs[5]  = '{8'h01, 8'h01, 8'h00, 8'h00, 1'b0};
        vecs[6]  = '{8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0};
        vecs[7]  = '{8'h80, 8'h7F, 8'h01, 8'h80, 1'b1};
        vecs[8]  = '{8'h7F, 8'h80, 8'hFF, 8'h7F, 1'b1};
        vecs[9]  = '{8'h00, 8'h01, 8'hFF, 8'hFF, 1'b0};
        vecs[10] = '{8'h80, 8'h80, 8'h00, 8'h00, 1'b0};
        vecs[11] = '{8'hC8, 8'h37, 8'h91, 8'h91, 1'b0};
        vecs[12] = '{8'h64, 8'h9C, 8'hC8, 8'h7F, 1'b1};
        vecs[13] = '{8'h40, 8'hC0, 8'h80, 8'h7F, 1'b1};

        areset_n  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset d", 32'(d), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        areset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, pick_d(vecs[i]),
                  vecs[i].ovf, i % 3, 1'b0);
        end

        do_op("backpressure", 8'h10, 8'h20, 8'hF0, 1'b0, 3, 1'b0);

        // Abort mid-RUN: reset must act without waiting for a clock edge.
        @(negedge clk);
        a = 8'h12;
        b = 8'h34;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        areset_n = 1'b0;
        #1;
        chk("midrun rst in_ready", 32'(in_ready), 32'd1);
        chk("midrun rst out_valid", 32'(out_valid), 32'd0);
        chk("midrun rst d", 32'(d), 32'd0);
        chk("midrun rst overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        areset_n = 1'b1;
        do_op("after reset", 8'h01, 8'h01, 8'h00, 1'b0, 0, 1'b0);

        do_op("ignore in RUN", 8'h40, 8'hC0, pick_d(vecs[13]), 1'b1, 2, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("no second op", 32'({in_ready, out_valid}), 32'b10);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
